// File: rtl/turn_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | turn_sequencer: keyboard-driven player/phase/round sequencer that builds |
// | the 2x16 ASCII text shown on the LCD.                                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module turn_sequencer #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_PHASES  = 3,
    parameter int MAX_ROUNDS  = 0,
    parameter int LOAD_CYCLES = 50000000
) (
    input  logic         CLOCK_50,
    input  logic         resetn,
    input  logic         key_valid,
    input  logic [7:0]   key_code,
    output logic [1:0]   state,
    output logic [3:0]   player,
    output logic [1:0]   phase,
    output logic [6:0]   round,
    output logic [255:0] msg,
    output logic         msg_update,
    output logic         game_over
);

    localparam logic [1:0]  S_LOADING   = 2'd0;
    localparam logic [1:0]  S_START     = 2'd1;
    localparam logic [1:0]  S_PLAY      = 2'd2;
    localparam logic [1:0]  S_GAME_OVER = 2'd3;

    localparam logic [7:0]  KEY_ENTER   = 8'h5A;
    localparam logic [7:0]  KEY_ESC     = 8'h76;
    localparam logic [7:0]  KEY_BKSP    = 8'h66;

    localparam logic [1:0]  LAST_PHASE  = 2'(NUM_PHASES - 1);
    localparam logic [3:0]  LAST_PLAYER = 4'(NUM_PLAYERS - 1);
    localparam logic [6:0]  LAST_ROUND  = 7'(MAX_ROUNDS);
    localparam logic [31:0] LOAD_LAST   = 32'(LOAD_CYCLES - 1);

    localparam logic [255:0] MSG_LOADING = {"Loading", {9{8'h20}}, {16{8'h20}}};
    localparam logic [255:0] MSG_START   = {"Laser Lift", {6{8'h20}}, "BattleBoard", {5{8'h20}}};
    localparam logic [255:0] MSG_OVER    = {"Game Over", {7{8'h20}}, "Press Enter", {5{8'h20}}};

    logic [1:0]   r_state, w_state_nx;
    logic [3:0]   r_player, w_player_nx;
    logic [1:0]   r_phase, w_phase_nx;
    logic [6:0]   r_round, w_round_nx;
    logic [31:0]  r_load_cnt, w_load_nx;
    logic         r_key_prev;
    logic         r_pending;
    logic [255:0] r_msg;
    logic         r_msg_update;

    logic         w_accept;
    logic         w_changed;
    logic [6:0]   w_tens, w_ones;
    logic [55:0]  w_phase_txt;
    logic [255:0] w_msg_text;

    assign w_accept  = key_valid & ~r_key_prev;
    assign w_changed = (w_state_nx != r_state) | (w_player_nx != r_player) |
                       (w_phase_nx != r_phase) | (w_round_nx != r_round);

    // Text lags the counters by one edge; r_pending marks that the counters moved.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_LOADING;
            r_player     <= 4'd0;
            r_phase      <= 2'd0;
            r_round      <= 7'd1;
            r_load_cnt   <= 32'd0;
            r_key_prev   <= 1'b0;
            r_pending    <= 1'b0;
            r_msg        <= MSG_LOADING;
            r_msg_update <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_player     <= w_player_nx;
            r_phase      <= w_phase_nx;
            r_round      <= w_round_nx;
            r_load_cnt   <= w_load_nx;
            r_key_prev   <= key_valid;
            r_pending    <= w_changed;
            r_msg_update <= r_pending;
            if (r_pending) begin
                r_msg <= w_msg_text;
            end
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_player_nx = r_player;
        w_phase_nx  = r_phase;
        w_round_nx  = r_round;
        w_load_nx   = r_load_cnt;
        if (r_state == S_LOADING) begin
            w_load_nx = r_load_cnt + 32'd1;
            if (r_load_cnt == LOAD_LAST) begin
                w_state_nx = S_START;
            end
        end else if (w_accept && key_code == KEY_BKSP) begin
            w_state_nx  = S_START;
            w_player_nx = 4'd0;
            w_phase_nx  = 2'd0;
            w_round_nx  = 7'd1;
        end else if (w_accept && key_code == KEY_ENTER) begin
            case (r_state)
                S_START, S_GAME_OVER: begin
                    w_state_nx  = (r_state == S_START) ? S_PLAY : S_START;
                    w_player_nx = 4'd0;
                    w_phase_nx  = 2'd0;
                    w_round_nx  = 7'd1;
                end
                S_PLAY: begin
                    if (r_phase != LAST_PHASE) begin
                        w_phase_nx = r_phase + 2'd1;
                    end else if (r_player != LAST_PLAYER) begin
                        w_phase_nx  = 2'd0;
                        w_player_nx = r_player + 4'd1;
                    end else if (MAX_ROUNDS != 0 && r_round == LAST_ROUND) begin
                        w_state_nx = S_GAME_OVER;
                    end else begin
                        w_phase_nx  = 2'd0;
                        w_player_nx = 4'd0;
                        w_round_nx  = (r_round == 7'd99) ? 7'd1 : r_round + 7'd1;
                    end
                end
                default: ;
            endcase
        end else if (w_accept && key_code == KEY_ESC && r_state == S_PLAY) begin
            // Round 1 never borrows back to 99: the very first turn is a floor.
            if (r_phase != 2'd0) begin
                w_phase_nx = r_phase - 2'd1;
            end else if (r_player != 4'd0) begin
                w_phase_nx  = LAST_PHASE;
                w_player_nx = r_player - 4'd1;
            end else if (r_round != 7'd1) begin
                w_phase_nx  = LAST_PHASE;
                w_player_nx = LAST_PLAYER;
                w_round_nx  = r_round - 7'd1;
            end
        end
    end

    always_comb begin
        w_tens = r_round / 7'd10;
        w_ones = r_round % 7'd10;
        case (r_phase)
            2'd0:    w_phase_txt = {"Move", {3{8'h20}}};
            2'd1:    w_phase_txt = {"Attack", 8'h20};
            2'd2:    w_phase_txt = {"Aim", {4{8'h20}}};
            default: w_phase_txt = {"Fire", {3{8'h20}}};
        endcase
        case (r_state)
            S_START:     w_msg_text = MSG_START;
            S_PLAY:      w_msg_text = {"Player ", 8'h31 + {4'd0, r_player}, 8'h20, w_phase_txt,
                                       "Round ", 8'h30 + {1'b0, w_tens}, 8'h30 + {1'b0, w_ones},
                                       {8{8'h20}}};
            S_GAME_OVER: w_msg_text = MSG_OVER;
            default:     w_msg_text = MSG_LOADING;
        endcase
    end

    assign state      = r_state;
    assign player     = r_player;
    assign phase      = r_phase;
    assign round      = r_round;
    assign msg        = r_msg;
    assign msg_update = r_msg_update;
    assign game_over  = (r_state == S_GAME_OVER);

endmodule
`default_nettype wire

// File: tb/tb_turn_sequencer.sv
`default_nettype none
// tb_turn_sequencer: three differently-parameterised sequencers share one key stream
// and are compared against a position-index model plus a hand-written vector table.
module tb_turn_sequencer;

    localparam int NDUT = 3;
    localparam int ST_LOADING = 0, ST_START = 1, ST_PLAY = 2, ST_OVER = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic       key_valid;
    logic [7:0] key_code;

    logic [1:0]   d_state  [NDUT];
    logic [3:0]   d_player [NDUT];
    logic [1:0]   d_phase  [NDUT];
    logic [6:0]   d_round  [NDUT];
    logic [255:0] d_msg    [NDUT];
    logic         d_upd    [NDUT];
    logic         d_over   [NDUT];

    turn_sequencer #(.NUM_PLAYERS(2), .NUM_PHASES(3), .MAX_ROUNDS(0), .LOAD_CYCLES(4)) dut_a (
        .CLOCK_50(clk), .resetn(resetn), .key_valid(key_valid), .key_code(key_code),
        .state(d_state[0]), .player(d_player[0]), .phase(d_phase[0]), .round(d_round[0]),
        .msg(d_msg[0]), .msg_update(d_upd[0]), .game_over(d_over[0]));

    turn_sequencer #(.NUM_PLAYERS(2), .NUM_PHASES(3), .MAX_ROUNDS(2), .LOAD_CYCLES(6)) dut_b (
        .CLOCK_50(clk), .resetn(resetn), .key_valid(key_valid), .key_code(key_code),
        .state(d_state[1]), .player(d_player[1]), .phase(d_phase[1]), .round(d_round[1]),
        .msg(d_msg[1]), .msg_update(d_upd[1]), .game_over(d_over[1]));

    turn_sequencer #(.NUM_PLAYERS(9), .NUM_PHASES(4), .MAX_ROUNDS(0), .LOAD_CYCLES(4)) dut_c (
        .CLOCK_50(clk), .resetn(resetn), .key_valid(key_valid), .key_code(key_code),
        .state(d_state[2]), .player(d_player[2]), .phase(d_phase[2]), .round(d_round[2]),
        .msg(d_msg[2]), .msg_update(d_upd[2]), .game_over(d_over[2]));

    function automatic int cfg_np(int k);  return (k == 2) ? 9 : 2; endfunction
    function automatic int cfg_nph(int k); return (k == 2) ? 4 : 3; endfunction
    function automatic int cfg_max(int k); return (k == 1) ? 2 : 0; endfunction
    function automatic int cfg_load(int k); return (k == 1) ? 6 : 4; endfunction

    // Model: a linear turn index pos = ((round-1)*players + player)*phases + phase.
    int           m_state [NDUT];
    int           m_pos   [NDUT];
    int           m_load  [NDUT];
    bit           m_pend  [NDUT];
    bit           m_upd   [NDUT];
    logic [255:0] m_msg   [NDUT];
    bit           m_prev;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [127:0] to_line(string s);
        logic [127:0] r = {16{8'h20}};
        for (int i = 0; i < 16; i++)
            if (i < s.len()) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    function automatic string phase_name(int p);
        case (p)
            0: return "Move";
            1: return "Attack";
            2: return "Aim";
            default: return "Fire";
        endcase
    endfunction

    function automatic int m_phase(int k);  return m_pos[k] % cfg_nph(k); endfunction
    function automatic int m_player(int k); return (m_pos[k] / cfg_nph(k)) % cfg_np(k); endfunction
    function automatic int m_round(int k);  return m_pos[k] / (cfg_nph(k) * cfg_np(k)) + 1; endfunction

    function automatic logic [255:0] model_text(int k);
        string l1, l2;
        case (m_state[k])
            ST_LOADING: begin l1 = "Loading"; l2 = ""; end
            ST_START:   begin l1 = "Laser Lift"; l2 = "BattleBoard"; end
            ST_PLAY: begin
                l1 = $sformatf("Player %0d %s", m_player(k) + 1, phase_name(m_phase(k)));
                l2 = $sformatf("Round %02d", m_round(k));
            end
            default:    begin l1 = "Game Over"; l2 = "Press Enter"; end
        endcase
        return {to_line(l1), to_line(l2)};
    endfunction

    task automatic model_reset();
        m_prev = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            m_state[k] = ST_LOADING; m_pos[k] = 0; m_load[k] = 0;
            m_pend[k] = 1'b0; m_upd[k] = 1'b0;
            m_msg[k] = {to_line("Loading"), to_line("")};
        end
    endtask

    task automatic model_edge(bit kv, logic [7:0] kc);
        bit acc = kv && !m_prev;
        m_prev = kv;
        for (int k = 0; k < NDUT; k++) begin
            int ns = m_state[k];
            int np = m_pos[k];
            int per_round = cfg_np(k) * cfg_nph(k);
            if (m_state[k] == ST_LOADING) begin
                m_load[k]++;
                if (m_load[k] >= cfg_load(k)) ns = ST_START;
            end else if (acc) begin
                if (kc == 8'h66) begin
                    ns = ST_START; np = 0;
                end else if (kc == 8'h5A) begin
                    if (m_state[k] == ST_START) begin ns = ST_PLAY; np = 0; end
                    else if (m_state[k] == ST_OVER) begin ns = ST_START; np = 0; end
                    else if (cfg_max(k) != 0 && m_pos[k] + 1 == cfg_max(k) * per_round) ns = ST_OVER;
                    else np = (m_pos[k] + 1) % (99 * per_round);
                end else if (kc == 8'h76 && m_state[k] == ST_PLAY && m_pos[k] > 0) begin
                    np = m_pos[k] - 1;
                end
            end
            m_upd[k] = m_pend[k];
            if (m_pend[k]) m_msg[k] = model_text(k);
            m_pend[k] = (ns != m_state[k]) || (np != m_pos[k]);
            m_state[k] = ns;
            m_pos[k] = np;
        end
    endtask

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("dut%0d.state", k),  d_state[k],  m_state[k]);
            chk($sformatf("dut%0d.player", k), d_player[k], m_player(k));
            chk($sformatf("dut%0d.phase", k),  d_phase[k],  m_phase(k));
            chk($sformatf("dut%0d.round", k),  d_round[k],  m_round(k));
            chk($sformatf("dut%0d.msg", k),    d_msg[k],    m_msg[k]);
            chk($sformatf("dut%0d.msg_update", k), d_upd[k], m_upd[k]);
            chk($sformatf("dut%0d.game_over", k),  d_over[k], m_state[k] == ST_OVER);
        end
    endtask

    task automatic tick(bit kv, logic [7:0] kc);
        key_valid = kv;
        key_code  = kc;
        @(posedge clk);
        model_edge(kv, kc);
        #1;
        check_all();
    endtask

    task automatic press(logic [7:0] kc);
        tick(1'b1, kc);
        tick(1'b0, kc);
    endtask

    typedef struct {
        bit         kv;
        logic [7:0] kc;
        int         st, pl, ph, rd;
        bit         upd;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit kv, logic [7:0] kc, int st, int pl, int ph, int rd, bit upd);
        vec_t v = '{kv, kc, st, pl, ph, rd, upd};
        tbl.push_back(v);
    endfunction

    initial begin
        // Expected post-edge outputs of dut_a (2 players, 3 phases, 4 load clocks).
        for (int i = 0; i < 3; i++) add(0, 8'h00, ST_LOADING, 0, 0, 1, 0);
        add(0, 8'h00, ST_START, 0, 0, 1, 0);
        add(0, 8'h00, ST_START, 0, 0, 1, 1);
        add(0, 8'h00, ST_START, 0, 0, 1, 0);
        add(1, 8'h5A, ST_PLAY, 0, 0, 1, 0);
        add(1, 8'h5A, ST_PLAY, 0, 0, 1, 1);
        for (int i = 0; i < 8; i++) add(1, (i == 3) ? 8'h76 : 8'h5A, ST_PLAY, 0, 0, 1, 0);
        add(0, 8'h00, ST_PLAY, 0, 0, 1, 0);
        add(1, 8'h76, ST_PLAY, 0, 0, 1, 0);
        add(0, 8'h00, ST_PLAY, 0, 0, 1, 0);
        add(0, 8'h00, ST_PLAY, 0, 0, 1, 0);
        add(1, 8'h1C, ST_PLAY, 0, 0, 1, 0);
        add(0, 8'h00, ST_PLAY, 0, 0, 1, 0);
        add(1, 8'h5A, ST_PLAY, 0, 1, 1, 0); add(0, 8'h00, ST_PLAY, 0, 1, 1, 1);
        add(1, 8'h5A, ST_PLAY, 0, 2, 1, 0); add(0, 8'h00, ST_PLAY, 0, 2, 1, 1);
        add(1, 8'h5A, ST_PLAY, 1, 0, 1, 0); add(0, 8'h00, ST_PLAY, 1, 0, 1, 1);
        add(1, 8'h5A, ST_PLAY, 1, 1, 1, 0); add(0, 8'h00, ST_PLAY, 1, 1, 1, 1);
        add(1, 8'h5A, ST_PLAY, 1, 2, 1, 0); add(0, 8'h00, ST_PLAY, 1, 2, 1, 1);
        add(1, 8'h5A, ST_PLAY, 0, 0, 2, 0); add(0, 8'h00, ST_PLAY, 0, 0, 2, 1);
        add(1, 8'h76, ST_PLAY, 1, 2, 1, 0); add(0, 8'h00, ST_PLAY, 1, 2, 1, 1);
        add(1, 8'h66, ST_START, 0, 0, 1, 0); add(0, 8'h00, ST_START, 0, 0, 1, 1);
        add(1, 8'h5A, ST_PLAY, 0, 0, 1, 0); add(0, 8'h00, ST_PLAY, 0, 0, 1, 1);

        resetn = 1'b0;
        key_valid = 1'b0;
        key_code = 8'h00;
        model_reset();
        #12;
        check_all();
        resetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].kv, tbl[i].kc);
            chk($sformatf("tbl[%0d].state", i),  d_state[0],  tbl[i].st);
            chk($sformatf("tbl[%0d].player", i), d_player[0], tbl[i].pl);
            chk($sformatf("tbl[%0d].phase", i),  d_phase[0],  tbl[i].ph);
            chk($sformatf("tbl[%0d].round", i),  d_round[0],  tbl[i].rd);
            chk($sformatf("tbl[%0d].msg_update", i), d_upd[0], tbl[i].upd);
            if (i == 4) chk("start.line1", d_msg[0][255:128], to_line("Laser Lift"));
            if (i == 7) begin
                chk("play.line1", d_msg[0][255:128], to_line("Player 1 Move"));
                chk("play.line2", d_msg[0][127:0], to_line("Round 01"));
            end
            if (i == 36) chk("esc.line1", d_msg[0][255:128], to_line("Player 2 Aim"));
        end

        // MAX_ROUNDS=2: the twelfth ENTER ends the game.
        press(8'h66);
        press(8'h5A);
        for (int i = 0; i < 11; i++) press(8'h5A);
        chk("b.before_over", d_state[1], ST_PLAY);
        press(8'h5A);
        chk("b.over_state", d_state[1], ST_OVER);
        chk("b.over_flag", d_over[1], 1'b1);
        chk("b.over_line1", d_msg[1][255:128], to_line("Game Over"));
        press(8'h5A);
        chk("b.over_to_start", d_state[1], ST_START);

        // 9 players x 4 phases, unlimited rounds: walk to round 99 and wrap.
        press(8'h66);
        press(8'h5A);
        for (int i = 0; i < 98 * 36; i++) press(8'h5A);
        chk("c.round99", d_round[2], 7'd99);
        chk("c.line2_99", d_msg[2][127:0], to_line("Round 99"));
        for (int i = 0; i < 36; i++) press(8'h5A);
        chk("c.wrap_round", d_round[2], 7'd1);
        chk("c.wrap_line2", d_msg[2][127:0], to_line("Round 01"));
        chk("c.wrap_upd", d_upd[2], 1'b1);

        // Reset while an update is in flight.
        tick(1'b1, 8'h5A);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        chk("c.reset_upd_dropped", d_upd[2], 1'b0);
        #3;
        resetn = 1'b1;

        for (int i = 0; i < 2500; i++) begin
            int r = $urandom_range(0, 9);
            logic [7:0] kc;
            if (r < 5)       kc = 8'h5A;
            else if (r < 7)  kc = 8'h76;
            else if (r == 7) kc = 8'h66;
            else             kc = 8'($urandom_range(0, 255));
            tick(1'($urandom_range(0, 1)), kc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
